hovalaag_run_ctrl: RTL and testbench

//  Generates the Hovalaag CPU clock and the one-cycle tick qualifiers used by the

---
 rtl/hovalaag_run_pkg.sv | 28 ++
 rtl/hovalaag_clk_div.sv | 38 +++
 rtl/hovalaag_run_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_hovalaag_run_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hovalaag_run_pkg.sv
// Shared encodings for the Hovalaag run controller: front-panel modes, FSM states
// and halt_reason codes.
package hovalaag_run_pkg;

   typedef enum logic [1:0] {
      MODE_STOP  = 2'd0,
      MODE_STEP  = 2'd1,
      MODE_BURST = 2'd2,
      MODE_RUN   = 2'd3
   } run_mode_e;

   typedef enum logic [2:0] {
      ST_HALT    = 3'd0,
      ST_RUN_LO  = 3'd1,
      ST_RUN_HI  = 3'd2,
      ST_STEP_HI = 3'd3,
      ST_PAUSE   = 3'd4
   } run_state_e;

   typedef enum logic [2:0] {
      HR_NONE    = 3'd0,
      HR_STOPPED = 3'd1,
      HR_OUT1    = 3'd2,
      HR_BREAK   = 3'd3,
      HR_BURST   = 3'd4
   } halt_reason_e;

endpackage

// File: rtl/hovalaag_clk_div.sv
// Loadable down-counter that sets the length of each cpu_clk phase; expire is
// high while the count sits at zero.
module hovalaag_clk_div #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             hold,
   input  logic [DIV_W-1:0] reload,
   output logic             expire
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = reload;
      end else if (!hold && cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= reload;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/hovalaag_run_ctrl.sv
// Hovalaag CPU clock generator and run-mode controller (stop/step/burst/run, OUT1 pause,
// stall). Define HOVAL_BREAKPOINT_EN to build the PC breakpoint comparators.
module hovalaag_run_ctrl
   import hovalaag_run_pkg::*;
#(
   parameter int DIV_W      = 24,
   parameter int ADDR_W     = 8,
   parameter int NUM_BP     = 2,
   parameter int BURST_W    = 8,
   parameter int TICK_CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               mode,
   input  logic [DIV_W-1:0]         div_reload,
   input  logic                     step_req,
   input  logic [BURST_W-1:0]       burst_len,
   input  logic                     pause_on_out,
   input  logic                     resume,
   input  logic                     stall,
   input  logic                     out_valid,
   input  logic                     out_select,
   input  logic [ADDR_W-1:0]        pc,
   input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
   input  logic [NUM_BP-1:0]        bp_en,
   output logic                     cpu_clk,
   output logic                     cpu_tick,
   output logic                     cpu_tick_d,
   output logic                     running,
   output logic [2:0]               halt_reason,
   output logic [TICK_CNT_W-1:0]    tick_count
);

   localparam logic [BURST_W-1:0]    BURST_ONE = BURST_W'(1);
   localparam logic [TICK_CNT_W-1:0] TICK_ONE  = TICK_CNT_W'(1);

   run_mode_e             mode_e;
   run_state_e            state_q, state_d;
   halt_reason_e          halt_reason_q, halt_reason_d;
   logic                  cpu_clk_q, cpu_clk_d;
   logic                  tick_q, tick_d;
   logic                  tick_dly_q;
   logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
   logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic                  step_prev_q;
   logic                  pause_pend_q, pause_pend_d;
   logic                  bp_hold_q, bp_hold_d;
   logic                  bp_skip_q, bp_skip_d;
   logic                  step_edge, pause_trig, pause_hit, bp_hit;
   logic                  rise, fall, div_load, div_hold, div_expire;

   assign mode_e     = run_mode_e'(mode);
   assign step_edge  = step_req && !step_prev_q;
   assign pause_trig = out_valid && !out_select && pause_on_out;
   assign pause_hit  = pause_trig || pause_pend_q;

`ifdef HOVAL_BREAKPOINT_EN
   logic bp_match;

   always_comb begin
      bp_match = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (bp_en[i] && pc == bp_addr[i*ADDR_W +: ADDR_W]) bp_match = 1'b1;
      end
   end

   // The tick that resumes from a breakpoint must not re-hit the same address.
   assign bp_hit = bp_match && !bp_skip_q;
`else
   logic unused_bp;
   assign unused_bp = ^{pc, bp_addr, bp_en};
   assign bp_hit    = 1'b0;
`endif

   hovalaag_clk_div #(.DIV_W(DIV_W)) u_div (
      .clk    (clk),
      .reset  (reset),
      .load   (div_load),
      .hold   (div_hold),
      .reload (div_reload),
      .expire (div_expire)
   );

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d       = state_q;
      halt_reason_d = halt_reason_q;
      cpu_clk_d     = cpu_clk_q;
      tick_d        = 1'b0;
      tick_count_d  = tick_count_q;
      burst_cnt_d   = burst_cnt_q;
      pause_pend_d  = pause_pend_q;
      bp_hold_d     = bp_hold_q;
      bp_skip_d     = bp_skip_q;
      div_load      = 1'b0;
      div_hold      = 1'b0;
      rise          = 1'b0;
      fall          = 1'b0;

      case (state_q)
         ST_HALT: begin
            div_load = 1'b1;
            if (mode_e == MODE_RUN) begin
               if (bp_hold_q) begin
                  if (step_edge && !stall) begin
                     rise      = 1'b1;
                     state_d   = ST_RUN_HI;
                     bp_hold_d = 1'b0;
                  end
               end else begin
                  div_load = 1'b0;
                  div_hold = stall;
                  if (div_expire && !stall) begin
                     rise    = 1'b1;
                     state_d = ST_RUN_HI;
                  end
               end
            end else begin
               bp_hold_d = 1'b0;
               if (mode_e == MODE_STEP && step_edge && !stall) begin
                  rise    = 1'b1;
                  state_d = ST_STEP_HI;
               end else if (mode_e == MODE_BURST && step_edge && !stall && burst_len != '0) begin
                  rise        = 1'b1;
                  state_d     = ST_RUN_HI;
                  burst_cnt_d = burst_len - BURST_ONE;
               end
            end
         end

         ST_RUN_LO: begin
            div_hold = stall;
            if (mode_e != MODE_RUN && mode_e != MODE_BURST) begin
               state_d       = ST_HALT;
               halt_reason_d = HR_STOPPED;
            end else if (pause_hit) begin
               state_d       = ST_PAUSE;
               halt_reason_d = HR_OUT1;
            end else if (div_expire && !stall) begin
               rise    = 1'b1;
               state_d = ST_RUN_HI;
               if (mode_e == MODE_BURST) burst_cnt_d = burst_cnt_q - BURST_ONE;
            end
         end

         ST_RUN_HI, ST_STEP_HI: begin
            if (state_q == ST_STEP_HI || div_expire) begin
               fall = 1'b1;
               if (bp_hit) begin
                  state_d       = ST_HALT;
                  halt_reason_d = HR_BREAK;
                  bp_hold_d     = 1'b1;
                  bp_skip_d     = 1'b1;
               end else begin
                  bp_skip_d = 1'b0;
                  if (pause_hit) begin
                     state_d       = ST_PAUSE;
                     halt_reason_d = HR_OUT1;
                  end else if (state_q == ST_STEP_HI) begin
                     state_d       = ST_HALT;
                     halt_reason_d = HR_STOPPED;
                  end else if (mode_e == MODE_RUN) begin
                     state_d = ST_RUN_LO;
                  end else if (mode_e == MODE_BURST && burst_cnt_q != '0) begin
                     state_d = ST_RUN_LO;
                  end else if (mode_e == MODE_BURST) begin
                     state_d       = ST_HALT;
                     halt_reason_d = HR_BURST;
                  end else begin
                     state_d       = ST_HALT;
                     halt_reason_d = HR_STOPPED;
                  end
               end
            end
         end

         ST_PAUSE: begin
            div_load = 1'b1;
            if (resume && !pause_trig) begin
               if (mode_e == MODE_RUN || mode_e == MODE_BURST) begin
                  state_d = ST_RUN_LO;
               end else begin
                  state_d       = ST_HALT;
                  halt_reason_d = HR_STOPPED;
               end
            end
         end

         default: begin
            state_d       = ST_HALT;
            halt_reason_d = HR_STOPPED;
            cpu_clk_d     = 1'b0;
         end
      endcase

      if (rise) begin
         cpu_clk_d     = 1'b1;
         tick_d        = 1'b1;
         tick_count_d  = tick_count_q + TICK_ONE;
         halt_reason_d = HR_NONE;
      end
      if (fall) cpu_clk_d = 1'b0;
      if (rise || fall) div_load = 1'b1;

      // A pause request raised mid-high-phase is remembered until that phase ends.
      if (state_d == ST_PAUSE || state_d == ST_HALT) begin
         pause_pend_d = 1'b0;
      end else if (pause_trig) begin
         pause_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_HALT;
         halt_reason_q <= HR_STOPPED;
         cpu_clk_q     <= 1'b0;
         tick_q        <= 1'b0;
         tick_dly_q    <= 1'b0;
         tick_count_q  <= '0;
         burst_cnt_q   <= '0;
         step_prev_q   <= step_req;
         pause_pend_q  <= 1'b0;
         bp_hold_q     <= 1'b0;
         bp_skip_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         halt_reason_q <= halt_reason_d;
         cpu_clk_q     <= cpu_clk_d;
         tick_q        <= tick_d;
         tick_dly_q    <= tick_q;
         tick_count_q  <= tick_count_d;
         burst_cnt_q   <= burst_cnt_d;
         step_prev_q   <= step_req;
         pause_pend_q  <= pause_pend_d;
         bp_hold_q     <= bp_hold_d;
         bp_skip_q     <= bp_skip_d;
      end
   end

   assign cpu_clk     = cpu_clk_q;
   assign cpu_tick    = tick_q;
   assign cpu_tick_d  = tick_dly_q;
   assign running     = (state_q == ST_RUN_LO) || (state_q == ST_RUN_HI);
   assign halt_reason = halt_reason_q;
   assign tick_count  = tick_count_q;

endmodule

// File: tb/tb_hovalaag_run_ctrl.sv
// Directed bench for hovalaag_run_ctrl: reset, run divider, step, burst, OUT1 pause,
// stall freeze, breakpoints (HOVAL_BREAKPOINT_EN) and reset during a high phase.
module tb_hovalaag_run_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mode = 2'd0;
   logic [23:0] div_reload = 24'd3;
   logic        step_req = 1'b0;
   logic [7:0]  burst_len = 8'd0;
   logic        pause_on_out = 1'b0;
   logic        resume = 1'b0;
   logic        stall = 1'b0;
   logic        out_valid = 1'b0;
   logic        out_select = 1'b0;
   logic [7:0]  pc = 8'd0;
   logic [15:0] bp_addr = 16'd0;
   logic [1:0]  bp_en = 2'b00;
   logic        cpu_clk, cpu_tick, cpu_tick_d, running;
   logic [2:0]  halt_reason;
   logic [15:0] tick_count;

   int n_tests = 0;
   int n_failed = 0;

   hovalaag_run_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .mode         (mode),
      .div_reload   (div_reload),
      .step_req     (step_req),
      .burst_len    (burst_len),
      .pause_on_out (pause_on_out),
      .resume       (resume),
      .stall        (stall),
      .out_valid    (out_valid),
      .out_select   (out_select),
      .pc           (pc),
      .bp_addr      (bp_addr),
      .bp_en        (bp_en),
      .cpu_clk      (cpu_clk),
      .cpu_tick     (cpu_tick),
      .cpu_tick_d   (cpu_tick_d),
      .running      (running),
      .halt_reason  (halt_reason),
      .tick_count   (tick_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_tick(input int budget, output bit ok, output int cyc);
      ok = 1'b0;
      cyc = 0;
      while (!ok && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (cpu_tick) ok = 1'b1;
      end
   endtask

   // One clk with the bench's CPU model: pc advances on every issued tick.
   task automatic cyc_pc(inout int tk);
      @(negedge clk);
      if (cpu_tick) begin
         pc = pc + 8'd1;
         tk++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests++; if (cpu_clk !== 1'b0) begin n_failed++; $display("FAIL reset_cpu_clk: got %b want 0", cpu_clk); end
      n_tests++; if (cpu_tick !== 1'b0) begin n_failed++; $display("FAIL reset_cpu_tick: got %b want 0", cpu_tick); end
      n_tests++; if (cpu_tick_d !== 1'b0) begin n_failed++; $display("FAIL reset_cpu_tick_d: got %b want 0", cpu_tick_d); end
      n_tests++; if (running !== 1'b0) begin n_failed++; $display("FAIL reset_running: got %b want 0", running); end
      n_tests++; if (halt_reason !== 3'd1) begin n_failed++; $display("FAIL reset_halt_reason: got %0d want 1", halt_reason); end
      n_tests++; if (tick_count !== 16'd0) begin n_failed++; $display("FAIL reset_tick_count: got %0d want 0", tick_count); end
   endtask

   task automatic test_run();
      bit ok;
      int cyc, hi, tk;
      div_reload = 24'd3;
      mode = 2'd3;
      wait_tick(40, ok, cyc);
      n_tests++; if (ok !== 1'b1) begin n_failed++; $display("FAIL run_first_tick: got none within %0d clk want a tick", cyc); end
      n_tests++; if (tick_count !== 16'd1) begin n_failed++; $display("FAIL run_tick_count1: got %0d want 1", tick_count); end
      n_tests++; if (cpu_clk !== 1'b1 || running !== 1'b1) begin n_failed++; $display("FAIL run_high: got clk=%b run=%b want 1/1", cpu_clk, running); end
      n_tests++; if (halt_reason !== 3'd0) begin n_failed++; $display("FAIL run_halt_reason: got %0d want 0", halt_reason); end
      hi = 0;
      tk = 0;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         if (i == 1) begin
            n_tests++; if (cpu_tick_d !== 1'b1 || cpu_tick !== 1'b0) begin n_failed++; $display("FAIL run_tick_d: got tick=%b tick_d=%b want 0/1", cpu_tick, cpu_tick_d); end
         end
         if (cpu_clk) hi++;
         if (cpu_tick) tk++;
      end
      n_tests++; if (hi != 3 || tk != 0) begin n_failed++; $display("FAIL run_phase: got high=%0d ticks=%0d want 3/0", hi, tk); end
      wait_tick(20, ok, cyc);
      n_tests++; if (!ok || cyc != 1) begin n_failed++; $display("FAIL run_period_a: got ok=%b cyc=%0d want 1/1", ok, cyc); end
      wait_tick(20, ok, cyc);
      n_tests++; if (!ok || cyc != 8) begin n_failed++; $display("FAIL run_period_b: got ok=%b cyc=%0d want 1/8", ok, cyc); end
      n_tests++; if (tick_count !== 16'd3) begin n_failed++; $display("FAIL run_tick_count3: got %0d want 3", tick_count); end
      mode = 2'd0;
      repeat (10) @(negedge clk);
      n_tests++; if (running !== 1'b0 || cpu_clk !== 1'b0 || halt_reason !== 3'd1) begin n_failed++; $display("FAIL run_stop: got run=%b clk=%b hr=%0d want 0/0/1", running, cpu_clk, halt_reason); end
      n_tests++; if (tick_count !== 16'd3) begin n_failed++; $display("FAIL run_stop_count: got %0d want 3", tick_count); end
   endtask

   task automatic test_step();
      int hi, tk;
      mode = 2'd1;
      step_req = 1'b1;
      hi = 0;
      tk = 0;
      repeat (12) begin
         @(negedge clk);
         if (cpu_clk) hi++;
         if (cpu_tick) tk++;
      end
      n_tests++; if (tk != 1 || hi != 1) begin n_failed++; $display("FAIL step_single: got ticks=%0d high=%0d want 1/1", tk, hi); end
      n_tests++; if (halt_reason !== 3'd1 || running !== 1'b0) begin n_failed++; $display("FAIL step_halt: got hr=%0d run=%b want 1/0", halt_reason, running); end
      n_tests++; if (tick_count !== 16'd4) begin n_failed++; $display("FAIL step_count: got %0d want 4", tick_count); end
      step_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_burst();
      int tk;
      mode = 2'd2;
      div_reload = 24'd1;
      burst_len = 8'd5;
      step_req = 1'b1;
      tk = 0;
      repeat (60) begin
         @(negedge clk);
         if (cpu_tick) tk++;
      end
      n_tests++; if (tk != 5) begin n_failed++; $display("FAIL burst5_ticks: got %0d want 5", tk); end
      n_tests++; if (halt_reason !== 3'd4 || running !== 1'b0) begin n_failed++; $display("FAIL burst5_halt: got hr=%0d run=%b want 4/0", halt_reason, running); end
      n_tests++; if (tick_count !== 16'd9) begin n_failed++; $display("FAIL burst5_count: got %0d want 9", tick_count); end
      step_req = 1'b0;
      burst_len = 8'd0;
      repeat (2) @(negedge clk);
      step_req = 1'b1;
      tk = 0;
      repeat (20) begin
         @(negedge clk);
         if (cpu_tick) tk++;
      end
      n_tests++; if (tk != 0 || running !== 1'b0) begin n_failed++; $display("FAIL burst0: got ticks=%0d run=%b want 0/0", tk, running); end
      n_tests++; if (tick_count !== 16'd9 || halt_reason !== 3'd4) begin n_failed++; $display("FAIL burst0_state: got cnt=%0d hr=%0d want 9/4", tick_count, halt_reason); end
      step_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_pause_stall();
      bit ok;
      int cyc, tk;
      mode = 2'd3;
      div_reload = 24'd3;
      pause_on_out = 1'b1;
      wait_tick(40, ok, cyc);
      n_tests++; if (!ok || tick_count !== 16'd10) begin n_failed++; $display("FAIL pause_pre_tick: got ok=%b cnt=%0d want 1/10", ok, tick_count); end
      out_valid = 1'b1;
      out_select = 1'b0;
      @(negedge clk);
      out_valid = 1'b0;
      tk = 0;
      repeat (30) begin
         @(negedge clk);
         if (cpu_tick) tk++;
      end
      n_tests++; if (tk != 0) begin n_failed++; $display("FAIL pause_no_tick: got %0d ticks want 0", tk); end
      n_tests++; if (halt_reason !== 3'd2 || running !== 1'b0 || cpu_clk !== 1'b0) begin n_failed++; $display("FAIL pause_state: got hr=%0d run=%b clk=%b want 2/0/0", halt_reason, running, cpu_clk); end
      resume = 1'b1;
      out_valid = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      out_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (running !== 1'b0 || halt_reason !== 3'd2) begin n_failed++; $display("FAIL pause_wins: got run=%b hr=%0d want 0/2", running, halt_reason); end
      pause_on_out = 1'b0;
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      n_tests++; if (running !== 1'b1) begin n_failed++; $display("FAIL resume_run: got %b want 1", running); end
      wait_tick(20, ok, cyc);
      n_tests++; if (!ok || cyc != 4) begin n_failed++; $display("FAIL resume_tick: got ok=%b cyc=%0d want 1/4", ok, cyc); end
      n_tests++; if (tick_count !== 16'd11) begin n_failed++; $display("FAIL resume_count: got %0d want 11", tick_count); end
      repeat (4) @(negedge clk);
      n_tests++; if (cpu_clk !== 1'b0 || running !== 1'b1) begin n_failed++; $display("FAIL stall_pre: got clk=%b run=%b want 0/1", cpu_clk, running); end
      stall = 1'b1;
      tk = 0;
      repeat (20) begin
         @(negedge clk);
         if (cpu_tick) tk++;
      end
      n_tests++; if (tk != 0 || cpu_clk !== 1'b0) begin n_failed++; $display("FAIL stall_block: got ticks=%0d clk=%b want 0/0", tk, cpu_clk); end
      stall = 1'b0;
      wait_tick(20, ok, cyc);
      n_tests++; if (!ok || cyc != 4) begin n_failed++; $display("FAIL stall_frozen: got ok=%b cyc=%0d want 1/4", ok, cyc); end
      n_tests++; if (tick_count !== 16'd12) begin n_failed++; $display("FAIL stall_count: got %0d want 12", tick_count); end
      mode = 2'd0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_breakpoint();
      int tk;
      bp_addr = {8'h00, 8'h04};
      bp_en = 2'b01;
      pc = 8'd0;
      div_reload = 24'd0;
      mode = 2'd3;
      tk = 0;
      repeat (30) cyc_pc(tk);
`ifdef HOVAL_BREAKPOINT_EN
      n_tests++; if (tk != 4 || pc !== 8'd4) begin n_failed++; $display("FAIL bp_hit: got ticks=%0d pc=%0d want 4/4", tk, pc); end
      n_tests++; if (halt_reason !== 3'd3 || running !== 1'b0) begin n_failed++; $display("FAIL bp_halt: got hr=%0d run=%b want 3/0", halt_reason, running); end
      step_req = 1'b1;
      repeat (10) cyc_pc(tk);
      n_tests++; if (pc <= 8'd4) begin n_failed++; $display("FAIL bp_resume_pc: got %0d want above 4", pc); end
      n_tests++; if (halt_reason !== 3'd0 || running !== 1'b1) begin n_failed++; $display("FAIL bp_resume: got hr=%0d run=%b want 0/1", halt_reason, running); end
`else
      n_tests++; if (tk <= 4 || pc <= 8'd4) begin n_failed++; $display("FAIL bp_absent_run: got ticks=%0d pc=%0d want above 4", tk, pc); end
      n_tests++; if (halt_reason !== 3'd0 || running !== 1'b1) begin n_failed++; $display("FAIL bp_absent_state: got hr=%0d run=%b want 0/1", halt_reason, running); end
`endif
      mode = 2'd0;
      step_req = 1'b0;
      bp_en = 2'b00;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid_high();
      bit ok;
      int cyc;
      div_reload = 24'd3;
      mode = 2'd3;
      wait_tick(40, ok, cyc);
      n_tests++; if (!ok || cpu_clk !== 1'b1) begin n_failed++; $display("FAIL rst_pre: got ok=%b clk=%b want 1/1", ok, cpu_clk); end
      reset = 1'b1;
      @(negedge clk);
      n_tests++; if (cpu_clk !== 1'b0 || cpu_tick !== 1'b0) begin n_failed++; $display("FAIL rst_mid_clk: got clk=%b tick=%b want 0/0", cpu_clk, cpu_tick); end
      n_tests++; if (halt_reason !== 3'd1 || tick_count !== 16'd0 || running !== 1'b0) begin n_failed++; $display("FAIL rst_mid_state: got hr=%0d cnt=%0d run=%b want 1/0/0", halt_reason, tick_count, running); end
      mode = 2'd0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_run();
      test_step();
      test_burst();
      test_pause_stall();
      test_breakpoint();
      test_reset_mid_high();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
